// File: rtl/gpio_pkg.sv
// gpio_pkg: register map, widths and bus decode helper shared by the GPIO slave
package gpio_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 1 << ADDR_W;
  localparam int CTRL_LED = 0;

  typedef enum logic [ADDR_W-1:0] {
    ADDR_DATA_OUT = 3'd0,
    ADDR_DATA_IN  = 3'd1,
    ADDR_IRQ_MASK = 3'd2,
    ADDR_EDGE_CAP = 3'd3,
    ADDR_EDGE_SEL = 3'd4,
    ADDR_OUT_SET  = 3'd5,
    ADDR_OUT_CLR  = 3'd6,
    ADDR_CTRL     = 3'd7
  } gpio_addr_e;

  function automatic logic [NUM_REGS-1:0] wr_decode(input logic en, input logic [ADDR_W-1:0] a);
    return en ? NUM_REGS'(1) << a : '0;
  endfunction
endpackage

// File: rtl/gpio_debounce.sv
// gpio_debounce: one-bit synchroniser followed by a consecutive-mismatch debouncer
module gpio_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic stable_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   sample, mismatch, done;

  assign sample   = sync_q[SYNC_STAGES-1];
  assign mismatch = sample != stable_q;
  assign done     = cnt_q == CW'(DEBOUNCE_CYCLES - 1);
  assign stable_o = stable_q;

  // count consecutive cycles the sample disagrees with the accepted value; accept on the last one
  always_comb begin
    cnt_d    = (!mismatch || done) ? '0 : cnt_q + 1'b1;
    stable_d = (mismatch && done) ? sample : stable_q;
  end

  // synchroniser shift chain and debounce state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], async_i};
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end
endmodule

// File: rtl/avalon_gpio_slave.sv
// avalon_gpio_slave: Avalon-MM GPIO peripheral with debounced inputs, edge capture and level irq
module avalon_gpio_slave
  import gpio_pkg::*;
#(
  parameter int OUT_W           = 8,
  parameter int IN_W            = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic              clk_50mhz,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_chipselect,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              irq,
  input  logic [IN_W-1:0]   gpio_in,
  output logic [OUT_W-1:0]  gpio_out,
  output logic              led_don
);
  logic [OUT_W-1:0]    data_out_q, data_out_d, wd_out;
  logic [IN_W-1:0]     mask_q, mask_d, cap_q, cap_d, sel_q, sel_d, prev_q, db, edge_hit, wd_in;
  logic                led_q, led_d, irq_q;
  logic [DATA_W-1:0]   rdata_q, rd_mux;
  logic [NUM_REGS-1:0] wr_hit;
  logic                unused_wdata;

  assign wd_out       = avs_writedata[OUT_W-1:0];
  assign wd_in        = avs_writedata[IN_W-1:0];
  assign unused_wdata = ^avs_writedata[DATA_W-1:OUT_W];
  assign wr_hit       = wr_decode(avs_chipselect && avs_write, avs_address);
  assign avs_readdata = rdata_q;
  assign irq          = irq_q;
  assign gpio_out     = data_out_q;
  assign led_don      = led_q;

  for (genvar i = 0; i < IN_W; i++) begin : g_db
    gpio_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk_i   (clk_50mhz),
      .rst_ni  (reset_n),
      .async_i (gpio_in[i]),
      .stable_o(db[i])
    );
  end

  // per-bit edge select: rising when sel=0, falling when sel=1
  assign edge_hit = (~sel_q & db & ~prev_q) | (sel_q & ~db & prev_q);

  // register file next state; a fresh edge beats a same-cycle write-1-to-clear
  always_comb begin
    data_out_d = wr_hit[ADDR_DATA_OUT] ? wd_out :
                 wr_hit[ADDR_OUT_SET]  ? data_out_q | wd_out :
                 wr_hit[ADDR_OUT_CLR]  ? data_out_q & ~wd_out : data_out_q;
    mask_d     = wr_hit[ADDR_IRQ_MASK] ? wd_in : mask_q;
    sel_d      = wr_hit[ADDR_EDGE_SEL] ? wd_in : sel_q;
    led_d      = wr_hit[ADDR_CTRL] ? avs_writedata[CTRL_LED] : led_q;
    cap_d      = (cap_q & ~(wr_hit[ADDR_EDGE_CAP] ? wd_in : '0)) | edge_hit;
  end

  // read mux over pre-write register values; write-only and unused locations read 0
  always_comb begin
    rd_mux = '0;
    case (gpio_addr_e'(avs_address))
      ADDR_DATA_OUT: rd_mux[OUT_W-1:0] = data_out_q;
      ADDR_DATA_IN:  rd_mux[IN_W-1:0]  = db;
      ADDR_IRQ_MASK: rd_mux[IN_W-1:0]  = mask_q;
      ADDR_EDGE_CAP: rd_mux[IN_W-1:0]  = cap_q;
      ADDR_EDGE_SEL: rd_mux[IN_W-1:0]  = sel_q;
      ADDR_CTRL:     rd_mux[CTRL_LED]  = led_q;
      default:       rd_mux = '0;
    endcase
  end

  // state update; readdata only changes on a read so it holds between reads
  always_ff @(posedge clk_50mhz or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q <= '0;
      mask_q     <= '0;
      sel_q      <= '0;
      cap_q      <= '0;
      prev_q     <= '0;
      led_q      <= 1'b0;
      irq_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      data_out_q <= data_out_d;
      mask_q     <= mask_d;
      sel_q      <= sel_d;
      cap_q      <= cap_d;
      prev_q     <= db;
      led_q      <= led_d;
      irq_q      <= |(cap_q & mask_q);
      rdata_q    <= (avs_chipselect && avs_read) ? rd_mux : rdata_q;
    end
  end
endmodule
